mac_share_arbiter: RTL

Shares one registered multiply-add unit (y = reg(a*b) + c, all operands W bits, wrap-around) between N requesters. Each requester presents one operand triple with a valid/ready handshake. The block arbitrates among requesters, issues at most one operation per cycle into the shared unit, and returns the result tagged with the requester index. It is the controller in front of the DSP-mapped add/reg/mul datapath, and it holds that datapath internally.

---
 rtl/mac_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: N requesters share one registered multiply-add, y = reg(a*b) + c.
// Define MAC_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mac_share_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*W-1:0] req_c,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IDW-1:0] resp_id,
  output logic [W-1:0]   resp_y
);

  localparam logic [IDW:0]   NUM_REQ = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N-1);

  logic [W-1:0]   prod_r;
  logic [W-1:0]   c_r;
  logic [IDW-1:0] id_r;
  logic           valid_r;

  logic           can_issue_s;
  logic           grant_found_s;
  logic [IDW-1:0] grant_id_s;
  logic [IDW:0]   cand_s;
  logic           transfer_s;
  logic [W-1:0]   a_sel_s;
  logic [W-1:0]   b_sel_s;
  logic [W-1:0]   c_sel_s;

`ifndef MAC_SHARE_FIXED_PRIO_EN
  logic [IDW-1:0] ptr_r;
`endif

  // A pending result that is not being consumed blocks any new issue.
  assign can_issue_s = !valid_r || resp_ready;

  // Winner search: first valid requester from the start index upward, wrapping at N-1.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MAC_SHARE_FIXED_PRIO_EN
      cand_s = (IDW+1)'(k);
`else
      cand_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
`endif
      if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_id_s    = cand_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
        grant_id_s    = grant_id_s;
      end
    end
  end

  // Ready is one-hot on the winner and held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (reset && can_issue_s && grant_found_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign transfer_s = |(req_valid & req_ready);
  assign a_sel_s    = req_a[grant_id_s*W +: W];
  assign b_sel_s    = req_b[grant_id_s*W +: W];
  assign c_sel_s    = req_c[grant_id_s*W +: W];

  // Operation registers: load on transfer, hold under backpressure, drop valid once consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_r  <= '0;
      c_r     <= '0;
      id_r    <= '0;
      valid_r <= 1'b0;
    end else if (transfer_s) begin
      prod_r  <= a_sel_s * b_sel_s;
      c_r     <= c_sel_s;
      id_r    <= grant_id_s;
      valid_r <= 1'b1;
    end else if (resp_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifndef MAC_SHARE_FIXED_PRIO_EN
  // Round-robin pointer advances past the winner only when a grant is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (transfer_s) begin
      ptr_r <= (grant_id_s == LAST_ID) ? '0 : grant_id_s + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign resp_valid = valid_r;
  assign resp_id    = id_r;
  assign resp_y     = prod_r + c_r;

endmodule
